gps_tx_sched: RTL and testbench
===============================

GPS_TX_SCHED -- requirements
Module: gps_tx_sched

Interface
REQ-001 SHALL have parameter NBYTES, default 32, meaning the byte count of each formatted string vector.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each overrun counter.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port lat_vec  input  8*NBYTES  meaning the latitude string; byte j sits at bits [8*(NBYTES-j)-1 -: 8], and byte 0 is sent first.
REQ-006 SHALL have port lat_valid  input  1  meaning a one-cycle pulse that qualifies lat_vec.
REQ-007 SHALL have ports lon_vec and lon_valid, with the same widths and meaning, for the longitude string.
REQ-008 SHALL have port tx_data  output  8  meaning the byte offered to the shared UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  meaning tx_data is valid.
REQ-010 SHALL have port tx_ready  input  1  meaning the transmitter accepts the byte on this cycle.
REQ-011 SHALL have port busy  output  1  meaning the FSM is not in IDLE.
REQ-012 SHALL have ports lat_ovr and lon_ovr  output  CNT_W  meaning overrun counts.

Function
REQ-013 SHALL hold, per source, a 1-deep pending buffer (vector plus pend flag) that is separate from the active shift register.
REQ-014 SHALL capture the vector into the pending buffer on a source's valid pulse and set pend; if pend was already set, the new vector overwrites it (latest wins) and that source's ovr counter increments, saturating at all-ones.
REQ-015 SHALL implement the FSM states IDLE, SEND and, under the macro, CR and LF.
- IDLE -> SEND when any pend is set; the granted vector loads into the active register, the byte index is set to 0, and that pend is cleared.
REQ-016 SHALL arbitrate round-robin: when both pend flags are set, grant the source not served last; after reset, the last-served pointer is lon, so lat wins the first tie.
REQ-017 SHALL evaluate a valid pulse that arrives in the same cycle as IDLE->SEND only on the next arbitration, and SHALL NOT lose it.
REQ-018 SHALL, in SEND, skip a byte equal to 0x00 in one cycle with tx_valid low.
- A nonzero byte drives tx_valid high, and the index advances only on tx_valid & tx_ready.
REQ-019 SHALL hold tx_data stable while tx_valid is high and tx_ready is low; tx_valid SHALL NOT drop before acceptance.
REQ-020 SHALL leave SEND after index NBYTES-1 is consumed or skipped: go to CR if the macro is defined, else to IDLE.
REQ-021 SHALL, when idle with byte 0 nonzero, assert the first tx_valid exactly 2 cycles after the valid pulse (cycle 1: capture, cycle 2: load).
REQ-022 SHALL allow an all-NUL string to produce no data bytes: it emits only the terminator if the macro is defined, else nothing.
REQ-023 SHALL allow a valid pulse for the source currently being sent to fill its pending buffer without disturbing the active transfer.

Reset
REQ-024 SHALL, while rst is low, force tx_data=0x00, tx_valid=0, busy=0, lat_ovr=lon_ovr=0, both pend=0, FSM=IDLE, index=0, and last-served=lon.
REQ-025 SHALL abandon a transfer in progress on reset mid-operation, with no further bytes and no terminator.

Configuration
REQ-026 SHALL, with GPS_TX_CRLF_EN defined, emit 0x0D in state CR and then 0x0A in state LF after every string, each under the same handshake, then return to IDLE.
REQ-027 SHALL, without GPS_TX_CRLF_EN, omit the CR/LF states and go from SEND directly to IDLE.

Structure
REQ-028 SHALL take the state encoding, the CR/LF byte constants and the default NBYTES from the shared package gps_pkg.
REQ-029 SHALL place the per-source pending buffer in one sub-module, gps_str_slot, instantiated twice; the arbiter and FSM stay in the top level.

Verification
REQ-030 SHALL cover: lat_vec "lat:48.1173" (NUL padded), tx_ready tied 1, macro on -> bytes 'l','a','t',':','4','8','.','1','1','7','3',0x0D,0x0A; first tx_valid 2 cycles after the pulse.
REQ-031 SHALL cover: lat_valid and lon_valid in the same cycle after reset -> the full lat string, then the full lon string; lat_ovr=lon_ovr=0.
REQ-032 SHALL cover: tx_ready held low for 5 cycles on byte 3 -> tx_data is stable and tx_valid stays high for all 5 cycles, with no duplicated or dropped byte.
REQ-033 SHALL cover: three lon_valid pulses while a lat string is being sent -> only the third lon vector is sent, and lon_ovr=2.
REQ-034 SHALL cover: rst asserted low mid-SEND at byte 5 -> tx_valid=0 in the same cycle, all outputs at reset values, and no CR/LF follows.
REQ-035 SHALL cover: an all-NUL lat_vec with the macro off -> tx_valid never rises, and busy is high for NBYTES cycles.

Source files
------------

// File: rtl/gps_pkg.sv
// ---------------------------------------------------------------------------
// gps_pkg
//
// Purpose:
//   Shared definitions for the GPS string transmit scheduler: the FSM state
//   encoding, the line-terminator byte constants, the default string length
//   and a small byte helper used by the scheduler.
//
// Contents:
//   GPS_NBYTES_DEF : default byte count of each formatted string vector
//   GPS_CR/GPS_LF  : terminator bytes emitted when GPS_TX_CRLF_EN is defined
//   gps_state_t    : scheduler FSM encoding (CR/LF only reached with the macro)
//   gps_is_nul     : true for a NUL (0x00) padding byte
// ---------------------------------------------------------------------------
package gps_pkg;

  localparam int GPS_NBYTES_DEF = 32;

  localparam logic [7:0] GPS_CR = 8'h0D;
  localparam logic [7:0] GPS_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CR   = 2'd2,
    ST_LF   = 2'd3
  } gps_state_t;

  function automatic logic gps_is_nul(input logic [7:0] b);
    return (b == 8'h00);
  endfunction

endpackage

// File: rtl/gps_str_slot.sv
// ---------------------------------------------------------------------------
// gps_str_slot
//
// Purpose:
//   One-deep pending buffer for a single string source. A valid pulse
//   captures the incoming vector and raises pend. A second pulse before the
//   scheduler has taken the buffer overwrites it (latest wins) and bumps a
//   saturating overrun counter.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset
//   vec_in : incoming string vector
//   load   : one-cycle pulse qualifying vec_in
//   take   : scheduler consumes the buffered vector this cycle
//   vec    : buffered vector
//   pend   : buffered vector not yet consumed
//   ovr    : saturating count of overwritten (never sent) vectors
// ---------------------------------------------------------------------------
module gps_str_slot #(
  parameter int VW    = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VW-1:0]    vec_in,
  input  logic             load,
  input  logic             take,
  output logic [VW-1:0]    vec,
  output logic             pend,
  output logic [CNT_W-1:0] ovr
);

  // A load in the same cycle as a take keeps pend set: the old vector is
  // being handed to the scheduler, so nothing is lost and it is not counted
  // as an overrun. The new vector waits for the next arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec  <= '0;
      pend <= 1'b0;
      ovr  <= '0;
    end else begin
      if (load) begin
        vec  <= vec_in;
        pend <= 1'b1;
        if (pend && !take && (ovr != '1)) begin
          ovr <= ovr + CNT_W'(1);
        end
      end else if (take) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gps_tx_sched.sv
// ---------------------------------------------------------------------------
// gps_tx_sched
//
// Purpose:
//   Schedules two formatted GPS strings (latitude and longitude) onto one
//   shared byte-wide UART transmitter. Each source has its own one-deep
//   pending buffer; a round-robin arbiter picks which buffered string is
//   loaded into the active shift register, and the FSM then offers the
//   string byte by byte with a valid/ready handshake. NUL padding bytes are
//   skipped in one cycle without being offered.
//
// Configuration:
//   GPS_TX_CRLF_EN : when defined, every string is followed by 0x0D, 0x0A
//                    (states CR and LF). Undefined by default.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   lat_vec   : latitude string, byte 0 in the top 8 bits, sent first
//   lat_valid : one-cycle pulse qualifying lat_vec
//   lon_vec   : longitude string, same layout
//   lon_valid : one-cycle pulse qualifying lon_vec
//   tx_data   : byte offered to the UART transmitter
//   tx_valid  : tx_data is valid
//   tx_ready  : transmitter accepts tx_data this cycle
//   busy      : FSM is not idle
//   lat_ovr   : latitude overrun count (saturating)
//   lon_ovr   : longitude overrun count (saturating)
// ---------------------------------------------------------------------------
module gps_tx_sched
  import gps_pkg::*;
#(
  parameter int NBYTES = GPS_NBYTES_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NBYTES-1:0] lat_vec,
  input  logic                lat_valid,
  input  logic [8*NBYTES-1:0] lon_vec,
  input  logic                lon_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    lat_ovr,
  output logic [CNT_W-1:0]    lon_ovr
);

  localparam int VW    = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  gps_state_t        state;
  logic [VW-1:0]     active;
  logic [IDX_W-1:0]  idx;
  logic              last_lon;

  logic [VW-1:0]     lat_pvec;
  logic [VW-1:0]     lon_pvec;
  logic              lat_pend;
  logic              lon_pend;
  logic              grant_lat;
  logic              grant_lon;
  logic              take_lat;
  logic              take_lon;
  logic [VW-1:0]     grant_vec;
  logic [7:0]        grant_byte;
  logic [7:0]        next_byte;
  logic              advance;
  logic              last_byte;

  gps_str_slot #(
    .VW    (VW),
    .CNT_W (CNT_W)
  ) u_lat_slot (
    .clk    (clk),
    .rst    (rst),
    .vec_in (lat_vec),
    .load   (lat_valid),
    .take   (take_lat),
    .vec    (lat_pvec),
    .pend   (lat_pend),
    .ovr    (lat_ovr)
  );

  gps_str_slot #(
    .VW    (VW),
    .CNT_W (CNT_W)
  ) u_lon_slot (
    .clk    (clk),
    .rst    (rst),
    .vec_in (lon_vec),
    .load   (lon_valid),
    .take   (take_lon),
    .vec    (lon_pvec),
    .pend   (lon_pend),
    .ovr    (lon_ovr)
  );

  // Round-robin: lat wins a tie unless it was the last source served.
  // last_lon resets high so the very first tie goes to lat.
  assign grant_lat  = lat_pend & (~lon_pend | last_lon);
  assign grant_lon  = lon_pend & ~grant_lat;
  assign take_lat   = (state == ST_IDLE) & grant_lat;
  assign take_lon   = (state == ST_IDLE) & grant_lon;
  assign grant_vec  = grant_lat ? lat_pvec : lon_pvec;
  assign grant_byte = grant_vec[VW-1 -: 8];

  // The active register shifts left as bytes are consumed, so the current
  // byte is always the top byte and the following one sits just below it.
  // tx_valid is registered as "current byte is nonzero", so a NUL byte
  // advances immediately and a real byte waits for tx_ready.
  assign next_byte = active[VW-9 -: 8];
  assign advance   = (state == ST_SEND) & (~tx_valid | tx_ready);
  assign last_byte = (idx == LAST_IDX);

  assign busy = (state != ST_IDLE);

  // Scheduler FSM. tx_data/tx_valid are loaded together with the state
  // change that exposes a new byte, so the first byte appears in the cycle
  // right after the string is loaded and stays frozen while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      active   <= '0;
      idx      <= '0;
      last_lon <= 1'b1;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lat_pend | lon_pend) begin
            state    <= ST_SEND;
            active   <= grant_vec;
            idx      <= '0;
            last_lon <= grant_lon;
            tx_data  <= grant_byte;
            tx_valid <= !gps_is_nul(grant_byte);
          end
        end
        ST_SEND: begin
          if (advance) begin
            if (last_byte) begin
`ifdef GPS_TX_CRLF_EN
              state    <= ST_CR;
              tx_data  <= GPS_CR;
              tx_valid <= 1'b1;
`else
              state    <= ST_IDLE;
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
`endif
            end else begin
              active   <= active << 8;
              idx      <= idx + IDX_W'(1);
              tx_data  <= next_byte;
              tx_valid <= !gps_is_nul(next_byte);
            end
          end
        end
`ifdef GPS_TX_CRLF_EN
        ST_CR: begin
          if (tx_ready) begin
            state   <= ST_LF;
            tx_data <= GPS_LF;
          end
        end
        ST_LF: begin
          if (tx_ready) begin
            state    <= ST_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gps_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_gps_tx_sched
//
// Directed testbench for gps_tx_sched. Inputs change 1 time unit after the
// rising edge; accepted bytes are collected on the falling edge. Works with
// or without GPS_TX_CRLF_EN defined.
// ---------------------------------------------------------------------------
module tb_gps_tx_sched;

  localparam int NB = 32;

  logic            clk;
  logic            rst;
  logic [8*NB-1:0] lat_vec;
  logic            lat_valid;
  logic [8*NB-1:0] lon_vec;
  logic            lon_valid;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [7:0]      lat_ovr;
  logic [7:0]      lon_ovr;

  int checks;
  int errors;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  gps_tx_sched #(
    .NBYTES (NB),
    .CNT_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lat_vec   (lat_vec),
    .lat_valid (lat_valid),
    .lon_vec   (lon_vec),
    .lon_valid (lon_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .lat_ovr   (lat_ovr),
    .lon_ovr   (lon_ovr)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every byte handed over on a valid/ready handshake
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  function automatic logic [8*NB-1:0] make_vec(input string s);
    logic [8*NB-1:0] v;
    v = '0;
    for (int i = 0; i < s.len() && i < NB; i++) v[8*(NB-i)-1 -: 8] = s[i];
    return v;
  endfunction

  // Expected wire bytes for one string: its characters, then CR/LF if built in
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef GPS_TX_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    lat_valid = 1'b0;
    lon_valid = 1'b0;
    lat_vec   = '0;
    lon_vec   = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_lat(input string s);
    lat_vec   = make_vec(s);
    lat_valid = 1'b1;
    tick();
    lat_valid = 1'b0;
  endtask

  task automatic pulse_lon(input string s);
    lon_vec   = make_vec(s);
    lon_valid = 1'b1;
    tick();
    lon_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int min_bytes, input int max_cycles, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy && rx_q.size() >= min_bytes) begin
        timeout = 1'b0;
        break;
      end
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    lat_valid = 1'b0;
    lon_valid = 1'b0;
    lat_vec   = '0;
    lon_vec   = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (lat_ovr !== 8'h00) begin errors++; $display("[TB] FAIL reset_lat_ovr got %0d want 0", lat_ovr); end
    checks++; if (lon_ovr !== 8'h00) begin errors++; $display("[TB] FAIL reset_lon_ovr got %0d want 0", lon_ovr); end
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle busy=%b valid=%b want 0/0", busy, tx_valid); end
  endtask

  task automatic test_single();
    bit to;
    apply_reset();
    push_str("lat:48.1173");
    pulse_lat("lat:48.1173");
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_cycle1_valid got %b want 0", tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h6C) begin errors++; $display("[TB] FAIL single_first_byte valid=%b data=%h want 1/6c", tx_valid, tx_data); end
    run_until_idle(exp_q.size(), 200, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL single_timeout got busy=%b want idle", busy); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL single_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL single_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_tie();
    bit to;
    apply_reset();
    push_str("lat:48.1173");
    push_str("lon:011.5167");
    lat_vec   = make_vec("lat:48.1173");
    lon_vec   = make_vec("lon:011.5167");
    lat_valid = 1'b1;
    lon_valid = 1'b1;
    tick();
    lat_valid = 1'b0;
    lon_valid = 1'b0;
    run_until_idle(exp_q.size(), 300, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL tie_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL tie_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL tie_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
    checks++; if (lat_ovr !== 8'd0 || lon_ovr !== 8'd0) begin errors++; $display("[TB] FAIL tie_ovr got %0d/%0d want 0/0", lat_ovr, lon_ovr); end
  endtask

  task automatic test_stall();
    bit to;
    apply_reset();
    push_str("lat:48.1173");
    pulse_lat("lat:48.1173");
    tick();
    tick();
    tick();
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3A) begin errors++; $display("[TB] FAIL stall_byte3 valid=%b data=%h want 1/3a", tx_valid, tx_data); end
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3A) begin errors++; $display("[TB] FAIL stall_hold%0d valid=%b data=%h want 1/3a", c, tx_valid, tx_data); end
    end
    tx_ready = 1'b1;
    run_until_idle(exp_q.size(), 200, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL stall_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL stall_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL stall_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_overrun();
    bit to;
    apply_reset();
    push_str("lat:48.1173");
    push_str("lon:C3");
    pulse_lat("lat:48.1173");
    tick();
    pulse_lon("lon:A1");
    tick();
    pulse_lon("lon:B2");
    tick();
    pulse_lon("lon:C3");
    tick();
    checks++; if (lon_ovr !== 8'd2) begin errors++; $display("[TB] FAIL ovr_count_mid got %0d want 2", lon_ovr); end
    run_until_idle(exp_q.size(), 300, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL ovr_timeout got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL ovr_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ovr_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
    checks++; if (lon_ovr !== 8'd2) begin errors++; $display("[TB] FAIL ovr_lon_final got %0d want 2", lon_ovr); end
    checks++; if (lat_ovr !== 8'd0) begin errors++; $display("[TB] FAIL ovr_lat_final got %0d want 0", lat_ovr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pulse_lat("lat:48.1173");
    pulse_lon("lon:011.5167");
    for (int c = 0; c < 5; c++) tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h38) begin errors++; $display("[TB] FAIL rstmid_byte5 valid=%b data=%h want 1/38", tx_valid, tx_data); end
    rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_outs data=%h busy=%b want 00/0", tx_data, busy); end
    checks++; if (lat_ovr !== 8'd0 || lon_ovr !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_ovr got %0d/%0d want 0/0", lat_ovr, lon_ovr); end
    tick();
    rst = 1'b1;
    rx_q.delete();
    for (int c = 0; c < 60; c++) tick();
    checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL rstmid_after got %0d bytes want 0", rx_q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
  endtask

  task automatic test_all_nul();
    int  busy_cycles;
    bit  valid_seen;
    apply_reset();
    busy_cycles = 0;
    valid_seen  = 1'b0;
    pulse_lat("");
    tick();
    while (busy && busy_cycles < 200) begin
      busy_cycles++;
      if (tx_valid) valid_seen = 1'b1;
      tick();
    end
    tick();
`ifdef GPS_TX_CRLF_EN
    checks++; if (busy_cycles != NB + 2) begin errors++; $display("[TB] FAIL nul_busy got %0d want %0d", busy_cycles, NB + 2); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("[TB] FAIL nul_bytes got %0d want 2", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 8'h0D || rx_q[1] !== 8'h0A) begin errors++; $display("[TB] FAIL nul_term got %h %h want 0d 0a", rx_q[0], rx_q[1]); end
    end
`else
    checks++; if (busy_cycles != NB) begin errors++; $display("[TB] FAIL nul_busy got %0d want %0d", busy_cycles, NB); end
    checks++; if (valid_seen) begin errors++; $display("[TB] FAIL nul_valid got 1 want 0"); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL nul_bytes got %0d want 0", rx_q.size()); end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_tie();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_all_nul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
